// File: rtl/sha2_stream_core.sv
// rtl/sha2_stream_core.sv - SHA-224/SHA-256 compression core with word-stream input and beat-stream digest output
// Optional SHA2_BLOCK_CNT_EN adds blk_cnt, a count of completed UPDATE cycles.
module sha2_stream_core #(
  parameter int MODE_224 = 0,
  parameter int OUT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
`ifdef SHA2_BLOCK_CNT_EN
  output logic [31:0]      blk_cnt,
`endif
  output logic             busy
);
  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_ROUND  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  localparam int DW = (MODE_224 != 0) ? 7 : 8;
  localparam int BEATS = (DW * 32 + OUT_W - 1) / OUT_W;
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  generate
    if (OUT_W != 32 && OUT_W != 64) begin : g_bad_out_w
      $error("sha2_stream_core: OUT_W must be 32 or 64");
    end
  endgenerate

  function automatic logic [31:0] iv(input int i);
    logic [255:0] v;
    v = (MODE_224 != 0)
      ? 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4
      : 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    v = v << (32 * i);
    return v[255:224];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [1:0]  state;
  logic [3:0]  word_cnt;
  logic [5:0]  round_cnt;
  logic        last_q;
  logic [31:0] h_r [8];
  logic [31:0] v [8];
  logic [31:0] w [16];
  logic [31:0] t1, t2, w_new;
  logic [31:0] dword [8];
  logic [OUT_W-1:0] beat_data;

  // w[0] is always W[t] for the current round; w_new becomes W[t+16]
  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
       + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round_cnt] + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      word_cnt  <= '0;
      round_cnt <= '0;
      last_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_r[i] <= iv(i);
        v[i]   <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= in_data;
            if (word_cnt == 4'd15) begin
              last_q   <= in_last;
              word_cnt <= '0;
              for (int i = 0; i < 8; i++) v[i] <= h_r[i];
              state    <= S_ROUND;
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end
        S_ROUND: begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
          w[15]     <= w_new;
          round_cnt <= round_cnt + 6'd1;
          if (round_cnt == 6'd63) state <= S_UPDATE;
        end
        S_UPDATE: begin
          for (int i = 0; i < 8; i++) h_r[i] <= h_r[i] + v[i];
          state <= last_q ? S_OUT : S_LOAD;
        end
        default: begin
          // word_cnt doubles as the digest beat index while in OUT
          if (out_ready) begin
            if (word_cnt == LAST_BEAT) begin
              for (int i = 0; i < 8; i++) h_r[i] <= iv(i);
              word_cnt <= '0;
              state    <= S_LOAD;
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef SHA2_BLOCK_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blk_cnt <= '0;
    else if (state == S_UPDATE) blk_cnt <= blk_cnt + 32'd1;
  end
`endif

  always_comb begin
    for (int i = 0; i < 7; i++) dword[i] = h_r[i];
    dword[7] = (MODE_224 != 0) ? 32'h0 : h_r[7];
  end

  generate
    if (OUT_W == 64) begin : g_w64
      assign beat_data = {dword[{word_cnt[1:0], 1'b0}], dword[{word_cnt[1:0], 1'b1}]};
    end else begin : g_w32
      assign beat_data = dword[word_cnt[2:0]];
    end
  endgenerate

  assign in_ready  = (state == S_LOAD) && !rst;
  assign busy      = (state != S_LOAD);
  assign out_valid = (state == S_OUT);
  assign out_last  = (state == S_OUT) && (word_cnt == LAST_BEAT);
  assign out_data  = (state == S_OUT) ? beat_data : '0;

endmodule

// File: tb/tb_sha2_stream_core.sv
// tb/tb_sha2_stream_core.sv - self-checking bench for sha2_stream_core in four MODE_224/OUT_W configurations
module tb_sha2_stream_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        ir [4];
  logic        ov [4];
  logic        ol [4];
  logic        bz [4];
  logic [63:0] od [4];
  logic [31:0] d0, d1;
  logic [63:0] d2, d3;
`ifdef SHA2_BLOCK_CNT_EN
  logic [31:0] bc [4];
`endif
  bit rand_ordy = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  localparam int NB [4] = '{8, 7, 4, 4};
  localparam bit MD [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam int WD [4] = '{32, 32, 64, 64};

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ABC224 = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
  localparam logic [255:0] TWO256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha2_stream_core #(.MODE_224(0), .OUT_W(32)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_data(d0), .out_last(ol[0]),
`ifdef SHA2_BLOCK_CNT_EN
    .blk_cnt(bc[0]),
`endif
    .busy(bz[0]));
  sha2_stream_core #(.MODE_224(1), .OUT_W(32)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_data(d1), .out_last(ol[1]),
`ifdef SHA2_BLOCK_CNT_EN
    .blk_cnt(bc[1]),
`endif
    .busy(bz[1]));
  sha2_stream_core #(.MODE_224(0), .OUT_W(64)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_data(d2), .out_last(ol[2]),
`ifdef SHA2_BLOCK_CNT_EN
    .blk_cnt(bc[2]),
`endif
    .busy(bz[2]));
  sha2_stream_core #(.MODE_224(1), .OUT_W(64)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready), .out_data(d3), .out_last(ol[3]),
`ifdef SHA2_BLOCK_CNT_EN
    .blk_cnt(bc[3]),
`endif
    .busy(bz[3]));

  always_comb begin
    od[0] = {32'h0, d0};
    od[1] = {32'h0, d1};
    od[2] = d2;
    od[3] = d3;
  end

  // Reference model: straightforward FIPS 180-4 compression of one block
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_block(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] wv [64];
    logic [31:0] hv [8];
    logic [31:0] s [8];
    logic [31:0] x1, x2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) wv[t] = m[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++)
      wv[t] = (rr(wv[t-2], 17) ^ rr(wv[t-2], 19) ^ (wv[t-2] >> 10)) + wv[t-7]
            + (rr(wv[t-15], 7) ^ rr(wv[t-15], 18) ^ (wv[t-15] >> 3)) + wv[t-16];
    for (int i = 0; i < 8; i++) begin
      hv[i] = hin[255 - 32 * i -: 32];
      s[i]  = hv[i];
    end
    for (int t = 0; t < 64; t++) begin
      x1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + wv[t];
      x2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + x1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hv[i] + s[i];
    return r;
  endfunction

  function automatic logic [63:0] exp_beat(input int k, input logic [255:0] h, input int b);
    logic [255:0] hh;
    hh = h;
    if (MD[k]) hh[31:0] = 32'h0;
    if (WD[k] == 32) return {32'h0, hh[255 - 32 * b -: 32]};
    return hh[255 - 64 * b -: 64];
  endfunction

  function automatic logic [511:0] abc_block();
    logic [511:0] m;
    m = '0;
    m[511:480] = 32'h61626380;
    m[31:0]    = 32'h00000018;
    return m;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[511 - 32 * i -: 32] = $urandom;
    return m;
  endfunction

  logic [63:0] qd [4][$];
  bit          ql [4][$];
  bit          prv_stall [4];
  logic [63:0] prv_d [4];
  logic        prv_l [4];

  // Beat collection plus stall-stability and no-input-while-busy monitors
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        prv_stall[k] = 1'b0;
      end else begin
        if (prv_stall[k]) begin
          vectors++;
          if (ov[k] !== 1'b1 || od[k] !== prv_d[k] || ol[k] !== prv_l[k]) begin
            miscompares++;
            $display("FAIL stall_hold[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b", k, ov[k], od[k], ol[k], prv_d[k], prv_l[k]);
          end
        end
        if (bz[k]) begin
          vectors++;
          if (ir[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_while_busy[%0d] got in_ready=%b want 0", k, ir[k]);
          end
        end
        if (ov[k] && out_ready) begin
          qd[k].push_back(od[k]);
          ql[k].push_back(ol[k]);
        end
        prv_stall[k] = ov[k] && !out_ready;
        prv_d[k] = od[k];
        prv_l[k] = ol[k];
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ordy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_block(input logic [511:0] blk, input bit last, input int gap_pct);
    int n;
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = blk[511 - 32 * i -: 32];
      in_last  = (i == 15) ? last : ($urandom_range(0, 1) == 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(ir[0] && ir[1] && ir[2] && ir[3]) && n < 400);
      if (!(ir[0] && ir[1] && ir[2] && ir[3])) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout word %0d got in_ready low want high", i);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (n < 600 && !(qd[0].size() >= 8 && qd[1].size() >= 7 && qd[2].size() >= 4 && qd[3].size() >= 4)) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ir[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_in_ready_held[%0d] got %b want 0", k, ir[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || ol[k] !== 1'b0 || od[k] !== 64'h0 || bz[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state[%0d] got rdy=%b v=%b l=%b d=%h busy=%b want 1 0 0 0 0", k, ir[k], ov[k], ol[k], od[k], bz[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    int n;
    bit bad;
    logic [255:0] hx;
    send_block(abc_block(), 1'b1, 0);
    n = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!ov[0] && (bz[0] !== 1'b1 || ir[0] !== 1'b0)) bad = 1'b1;
    end while (!ov[0] && n < 200);
    vectors++;
    if (n != 66) begin
      miscompares++;
      $display("FAIL abc_latency got %0d want 66", n);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL abc_busy_window got busy/in_ready wrong want busy=1 in_ready=0");
    end
    wait_out();
    for (int k = 0; k < 4; k++) begin
      hx = MD[k] ? ABC224 : ABC256;
      vectors++;
      if (qd[k].size() != NB[k]) begin
        miscompares++;
        $display("FAIL abc_beat_count[%0d] got %0d want %0d", k, qd[k].size(), NB[k]);
      end
      for (int b = 0; b < NB[k] && b < qd[k].size(); b++) begin
        vectors++;
        if (qd[k][b] !== exp_beat(k, hx, b) || ql[k][b] !== (b == NB[k] - 1)) begin
          miscompares++;
          $display("FAIL abc_beat[%0d][%0d] got %h/%0b want %h/%0b", k, b, qd[k][b], ql[k][b], exp_beat(k, hx, b), b == NB[k] - 1);
        end
      end
      qd[k].delete();
      ql[k].delete();
    end
  endtask

  task automatic test_two_block();
    logic [511:0] b1, b2;
    logic [255:0] h224, hx;
    b1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    b2 = '0;
    b2[31:0] = 32'h000001c0;
    h224 = ref_block(ref_block(IV224, b1), b2);
    send_block(b1, 1'b0, 0);
    send_block(b2, 1'b1, 0);
    wait_out();
    for (int k = 0; k < 4; k++) begin
      hx = MD[k] ? h224 : TWO256;
      vectors++;
      if (qd[k].size() != NB[k]) begin
        miscompares++;
        $display("FAIL two_beat_count[%0d] got %0d want %0d", k, qd[k].size(), NB[k]);
      end
      for (int b = 0; b < NB[k] && b < qd[k].size(); b++) begin
        vectors++;
        if (qd[k][b] !== exp_beat(k, hx, b) || ql[k][b] !== (b == NB[k] - 1)) begin
          miscompares++;
          $display("FAIL two_beat[%0d][%0d] got %h/%0b want %h/%0b", k, b, qd[k][b], ql[k][b], exp_beat(k, hx, b), b == NB[k] - 1);
        end
      end
      qd[k].delete();
      ql[k].delete();
    end
  endtask

  task automatic test_random_stream();
    logic [511:0] blk;
    logic [255:0] h256, h224, hx;
    int nblk;
    rand_ordy = 1'b1;
    for (int msg = 0; msg < 4; msg++) begin
      h256 = IV256;
      h224 = IV224;
      nblk = (msg == 0) ? 1 : $urandom_range(1, 3);
      for (int j = 0; j < nblk; j++) begin
        blk = (msg == 0) ? abc_block() : rand_block();
        h256 = ref_block(h256, blk);
        h224 = ref_block(h224, blk);
        send_block(blk, j == nblk - 1, 30);
      end
      wait_out();
      for (int k = 0; k < 4; k++) begin
        hx = MD[k] ? h224 : h256;
        vectors++;
        if (qd[k].size() != NB[k]) begin
          miscompares++;
          $display("FAIL rand_beat_count[%0d] msg %0d got %0d want %0d", k, msg, qd[k].size(), NB[k]);
        end
        for (int b = 0; b < NB[k] && b < qd[k].size(); b++) begin
          vectors++;
          if (qd[k][b] !== exp_beat(k, hx, b) || ql[k][b] !== (b == NB[k] - 1)) begin
            miscompares++;
            $display("FAIL rand_beat[%0d][%0d] msg %0d got %h/%0b want %h/%0b", k, b, msg, qd[k][b], ql[k][b], exp_beat(k, hx, b), b == NB[k] - 1);
          end
        end
        qd[k].delete();
        ql[k].delete();
      end
    end
    rand_ordy = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_round();
    logic [255:0] hx;
    send_block(abc_block(), 1'b1, 0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ir[k] !== 1'b0 || bz[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_during[%0d] got rdy=%b busy=%b want 0 0", k, ir[k], bz[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (qd[k].size() != 0 || ir[k] !== 1'b1 || bz[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_after[%0d] got beats=%0d rdy=%b busy=%b want 0 1 0", k, qd[k].size(), ir[k], bz[k]);
      end
      qd[k].delete();
      ql[k].delete();
    end
    @(posedge clk);
    #1;
    send_block(abc_block(), 1'b1, 0);
    wait_out();
    for (int k = 0; k < 4; k++) begin
      hx = MD[k] ? ref_block(IV224, abc_block()) : ref_block(IV256, abc_block());
      vectors++;
      if (qd[k].size() != NB[k]) begin
        miscompares++;
        $display("FAIL resend_beat_count[%0d] got %0d want %0d", k, qd[k].size(), NB[k]);
      end
      for (int b = 0; b < NB[k] && b < qd[k].size(); b++) begin
        vectors++;
        if (qd[k][b] !== exp_beat(k, hx, b) || ql[k][b] !== (b == NB[k] - 1)) begin
          miscompares++;
          $display("FAIL resend_beat[%0d][%0d] got %h/%0b want %h/%0b", k, b, qd[k][b], ql[k][b], exp_beat(k, hx, b), b == NB[k] - 1);
        end
      end
      qd[k].delete();
      ql[k].delete();
    end
  endtask

`ifdef SHA2_BLOCK_CNT_EN
  task automatic test_blk_cnt();
    logic [511:0] blks [3];
    bit lasts [3];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bc[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL blk_cnt_reset got %0d want 0", bc[0]);
    end
    blks[0] = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    blks[1] = '0;
    blks[1][31:0] = 32'h000001c0;
    blks[2] = abc_block();
    lasts = '{1'b0, 1'b1, 1'b1};
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      send_block(blks[j], lasts[j], 0);
      repeat (65) @(negedge clk);
      vectors++;
      if (bc[0] !== 32'(j)) begin
        miscompares++;
        $display("FAIL blk_cnt_pre[%0d] got %0d want %0d", j, bc[0], j);
      end
      @(negedge clk);
      vectors++;
      if (bc[0] !== 32'(j + 1)) begin
        miscompares++;
        $display("FAIL blk_cnt_post[%0d] got %0d want %0d", j, bc[0], j + 1);
      end
      if (lasts[j]) wait_out();
      else begin
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 4; k++) begin
        qd[k].delete();
        ql[k].delete();
      end
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bc[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL blk_cnt_cleared got %0d want 0", bc[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_random_stream();
    test_reset_mid_round();
`ifdef SHA2_BLOCK_CNT_EN
    test_blk_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
